lane_sel_arbiter: RTL
=====================

LANE_SEL_ARBITER -- requirements
Module: lane_sel_arbiter

Interface
- REQ-001: Parameter MAX_BURST, default 8, SHALL set the maximum consecutive grant cycles per holder; legal range 1..16.
- REQ-002: clk  input  1  sole clock; all state updates on rising edge.
- REQ-003: rst_n  input  1  asynchronous active-low reset.
- REQ-004: en  input  1  arbitration enable; when low, no new grant is issued.
- REQ-005: req  input  5  level requests; requester k (index 0..4) drives req[4-k], matching one-hot lane order.
- REQ-006: sel_idx  output  3  index of current holder, 0..4.
- REQ-007: sel_val  output  1  grant valid; sel_idx is meaningful only when high.
- REQ-008: gnt  output  5  one-hot grant; equals 5'b10000 >> sel_idx when sel_val=1, else 0.
- REQ-009: busy  output  1  high while a burst is in progress (state BUSY).

Function
- REQ-010: FSM SHALL have two states, IDLE and BUSY; there are no other states.
- REQ-011: IDLE -> BUSY when en=1 and req != 0; grant appears the cycle after the request is sampled (1-cycle latency).
- REQ-012: Winner SHALL be the first requesting index at or after rr_ptr in order ptr, ptr+1, ..., wrapping 4 -> 0.
- REQ-013: In BUSY, sel_idx, sel_val and gnt SHALL remain stable; 3-bit burst counter increments each cycle.
- REQ-014: Release occurs in the cycle the holder's req is low, or in the cycle the counter equals MAX_BURST-1, whichever comes first.
- REQ-015: On release, rr_ptr SHALL become holder+1 mod 5; the 4 -> 0 wrap is mandatory.
- REQ-016: Handoff is zero-bubble: in the release cycle, if en=1 and any req is high, arbitration per REQ-012 uses the new rr_ptr and the next holder is granted on the next edge; otherwise go to IDLE.
- REQ-017: A capped holder still requesting gets lowest priority; it is regranted immediately only if no other request is high.
- REQ-018: en low during BUSY SHALL NOT truncate the current burst; it blocks only the next grant.
- REQ-019: sel_idx SHALL never take values 5..7; gnt SHALL never have more than one bit set.
- REQ-020: A holder whose req drops in its first granted cycle SHALL still receive exactly one grant cycle.

Reset
- REQ-021: rst_n low SHALL immediately force state IDLE, rr_ptr=0, counter=0, sel_idx=0, sel_val=0, gnt=0, busy=0, including mid-burst.
- REQ-022: First grant after reset release SHALL occur no earlier than the second rising edge with rst_n high.

Configuration
- REQ-023: Macro LANE_SEL_ARB_LOCK_EN, when defined, SHALL add input port lock (1 bit); while lock=1 in BUSY the MAX_BURST cap is ignored and release occurs only on holder req drop.
- REQ-024: Without LANE_SEL_ARB_LOCK_EN, no lock port exists and the cap always applies.

Structure
- REQ-025: Shared package lane_sel_pkg SHALL hold NUM_REQ=5, IDX_W=3, and the state enum {IDLE, BUSY}.
- REQ-026: gnt SHALL be produced by one instance of decoder_3to5 driven by (sel_idx, sel_val); no other sub-module.

Verification
- REQ-027: Reset, then req=5'b10000, en=1 -> cycle+1: sel_idx=0, gnt=10000, busy=1; release after 8 cycles; rr_ptr=1.
- REQ-028: req=5'b11111 held, MAX_BURST=2 -> grants rotate 0,0,1,1,2,2,3,3,4,4,0 with no idle cycles.
- REQ-029: Holder index 4, only req[4] (index 0) and req[0] (index 4) high, holder capped -> next grant is index 0 (wrap check).
- REQ-030: Single requester index 2 with cap reached -> immediately regranted index 2, busy stays 1.
- REQ-031: Assert rst_n=0 mid-burst at sel_idx=3 -> gnt=0 and sel_val=0 without waiting for an edge; next grant starts from rr_ptr=0.
- REQ-032: With LANE_SEL_ARB_LOCK_EN, lock=1, req index 1 held for 20 cycles -> single continuous 20-cycle grant; lock=0 -> release at cap.

Source files
------------

// File: rtl/lane_sel_pkg.sv
// Shared types and helpers for the five-lane round-robin burst arbiter.
package lane_sel_pkg;

   localparam int NUM_REQ = 5;
   localparam int IDX_W   = 3;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // First requesting index at or after ptr, wrapping 4 -> 0; lane k sits at req[4-k].
   function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                input logic [IDX_W-1:0]   ptr);
      logic [IDX_W-1:0] pick;
      logic [IDX_W-1:0] bit_pos;
      logic             found;
      int               cand;
      pick  = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand    = (int'(ptr) + i) % NUM_REQ;
         bit_pos = IDX_W'(NUM_REQ - 1 - cand);
         if (!found && req[bit_pos]) begin
            pick  = IDX_W'(cand);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
      return (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
   endfunction

endpackage

// File: rtl/lane_sel_arbiter_decoder.sv
// Index-to-one-hot lane decoder: lane 0 maps to the MSB, nothing is set when invalid.
module decoder_3to5
   import lane_sel_pkg::*;
(
   input  logic [IDX_W-1:0]   idx,
   input  logic               val,
   output logic [NUM_REQ-1:0] onehot
);

   // Out-of-range indices match no bit, so the output can never hold more than one 1.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bit
      assign onehot[gi] = val && (idx == IDX_W'(NUM_REQ - 1 - gi));
   end

endmodule

// File: rtl/lane_sel_arbiter.sv
// Round-robin burst arbiter over five lanes with zero-bubble handoff and a burst cap.
// Optional LANE_SEL_ARB_LOCK_EN adds a lock input that suspends the cap while high.
module lane_sel_arbiter
   import lane_sel_pkg::*;
#(
   parameter int MAX_BURST = 8
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic [NUM_REQ-1:0] req,
`ifdef LANE_SEL_ARB_LOCK_EN
   input  logic               lock,
`endif
   output logic [IDX_W-1:0]   sel_idx,
   output logic               sel_val,
   output logic [NUM_REQ-1:0] gnt,
   output logic               busy
);

   // Three bits cover the default cap; a fourth is only needed for caps above 8.
   localparam int               CNT_W = (MAX_BURST > 8) ? 4 : 3;
   localparam logic [CNT_W-1:0] CAP   = CNT_W'(MAX_BURST - 1);

   state_t           state_reg, state_next;
   logic [IDX_W-1:0] holder_reg, holder_next;
   logic [IDX_W-1:0] ptr_reg, ptr_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             armed_reg;

   logic             lock_active;
   logic             holder_req;
   logic             cap_hit;
   logic             release_now;
   logic             can_grant;
   logic [IDX_W-1:0] search_ptr;
   logic [IDX_W-1:0] winner;

`ifdef LANE_SEL_ARB_LOCK_EN
   assign lock_active = lock;
`else
   assign lock_active = 1'b0;
`endif

   // armed_reg delays the first grant until the second edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         holder_reg <= '0;
         ptr_reg    <= '0;
         cnt_reg    <= '0;
         armed_reg  <= 1'b0;
      end else begin
         state_reg  <= state_next;
         holder_reg <= holder_next;
         ptr_reg    <= ptr_next;
         cnt_reg    <= cnt_next;
         armed_reg  <= 1'b1;
      end
   end

   assign holder_req  = req[IDX_W'(NUM_REQ - 1) - holder_reg];
   assign cap_hit     = (cnt_reg == CAP) && !lock_active;
   assign release_now = (state_reg == BUSY) && (!holder_req || cap_hit);
   assign search_ptr  = release_now ? next_idx(holder_reg) : ptr_reg;
   assign winner      = rr_pick(req, search_ptr);
   assign can_grant   = armed_reg && en && (|req);

   always_comb begin
      state_next  = state_reg;
      holder_next = holder_reg;
      ptr_next    = ptr_reg;
      cnt_next    = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (can_grant) begin
               state_next  = BUSY;
               holder_next = winner;
               cnt_next    = '0;
            end
         end
         BUSY: begin
            if (release_now) begin
               ptr_next = search_ptr;
               cnt_next = '0;
               if (can_grant) begin
                  holder_next = winner;
               end else begin
                  state_next = IDLE;
               end
            end else if (cnt_reg != CAP) begin
               // Saturate so a locked burst cannot wrap the counter.
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy    = (state_reg == BUSY);
      sel_val = (state_reg == BUSY);
      sel_idx = holder_reg;
   end

   decoder_3to5 u_dec (
      .idx    (sel_idx),
      .val    (sel_val),
      .onehot (gnt)
   );

endmodule
